// File: rtl/hssl_tx_link_keeper_if.sv
// Frame-source / transceiver-side signal bundle for the HSSL tx link keeper.
interface hssl_tx_link_keeper_if;
  logic [31:0] txdata_in;
  logic [3:0]  txkchr_in;
  logic        txvld_in;
  logic        txrdy_out;
  logic        link_ok_in;
  logic        stop_in;
  logic [31:0] tx_data_out;
  logic [3:0]  tx_charisk_out;
  logic [1:0]  state_out;
  logic [15:0] cc_cnt_out;

  modport master (
    output txdata_in, txkchr_in, txvld_in, link_ok_in, stop_in,
    input  txrdy_out, tx_data_out, tx_charisk_out, state_out, cc_cnt_out
  );

  modport slave (
    input  txdata_in, txkchr_in, txvld_in, link_ok_in, stop_in,
    output txrdy_out, tx_data_out, tx_charisk_out, state_out, cc_cnt_out
  );
endinterface

// File: rtl/hssl_tx_link_keeper.sv
// HSSL transmit link keeper: comma alignment until local rx sync, then frame
// forwarding with periodic clock-correction bursts. Outputs are registered.
module hssl_tx_link_keeper #(
  parameter int          ALIGN_WORDS = 16,
  parameter int          CC_PERIOD   = 1024,
  parameter int          CC_LEN      = 4,
  parameter logic [31:0] COMMA_WORD  = 32'h5050_50bc,
  parameter logic [3:0]  COMMA_KCHR  = 4'b0001,
  parameter logic [31:0] CC_WORD     = 32'hf7f7_f7f7
) (
  input logic                  clk,
  input logic                  reset,
  hssl_tx_link_keeper_if.slave lnk
);
  localparam int AW = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;
  localparam int PW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int BW = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_WORDS - 1);
  localparam logic [PW-1:0] PER_LAST   = PW'(CC_PERIOD - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(CC_LEN - 1);

  typedef enum logic [1:0] {
    DATA  = 2'b00,
    CC    = 2'b01,
    ALIGN = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] align_cnt, align_nxt;
  logic [PW-1:0] per_cnt, per_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic [15:0]   cc_cnt, cc_nxt;
  logic [31:0]   data_nxt;
  logic [3:0]    kchr_nxt;
  logic          hs;

  // Ready depends only on state and stop so it never loops back through txvld_in.
  assign lnk.txrdy_out  = (state == DATA) && !lnk.stop_in;
  assign hs             = lnk.txvld_in && lnk.txrdy_out;
  assign lnk.state_out  = state;
  assign lnk.cc_cnt_out = cc_cnt;

  // State, counters and the registered transceiver word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ALIGN;
      align_cnt          <= '0;
      per_cnt            <= '0;
      burst_cnt          <= '0;
      cc_cnt             <= '0;
      lnk.tx_data_out    <= COMMA_WORD;
      lnk.tx_charisk_out <= COMMA_KCHR;
    end else begin
      state              <= state_nxt;
      align_cnt          <= align_nxt;
      per_cnt            <= per_nxt;
      burst_cnt          <= burst_nxt;
      cc_cnt             <= cc_nxt;
      lnk.tx_data_out    <= data_nxt;
      lnk.tx_charisk_out <= kchr_nxt;
    end
  end

  // Next-state, counter updates and next tx word; loss of sync overrides all.
  always_comb begin
    state_nxt = state;
    align_nxt = align_cnt;
    per_nxt   = per_cnt;
    burst_nxt = burst_cnt;
    cc_nxt    = cc_cnt;
    data_nxt  = COMMA_WORD;
    kchr_nxt  = COMMA_KCHR;
    case (state)
      ALIGN: begin
        // Counter saturates, so DATA follows as soon as link_ok rises late.
        if (align_cnt != ALIGN_LAST) begin
          align_nxt = align_cnt + AW'(1);
        end else if (lnk.link_ok_in) begin
          state_nxt = DATA;
          align_nxt = '0;
          per_nxt   = '0;
        end
      end
      DATA: begin
        if (hs) begin
          data_nxt = lnk.txdata_in;
          kchr_nxt = lnk.txkchr_in;
        end
        // Period keeps running while stopped so CC insertion never stalls.
        if (per_cnt == PER_LAST) begin
          state_nxt = CC;
          per_nxt   = '0;
        end else begin
          per_nxt = per_cnt + PW'(1);
        end
      end
      CC: begin
        data_nxt = CC_WORD;
        kchr_nxt = 4'b1111;
        if (burst_cnt == BURST_LAST) begin
          state_nxt = DATA;
          burst_nxt = '0;
          cc_nxt    = cc_cnt + 16'd1;
        end else begin
          burst_nxt = burst_cnt + BW'(1);
        end
      end
      default: state_nxt = ALIGN;
    endcase
    // Aborted bursts are not counted: cc_nxt falls back to the held value.
    if (state != ALIGN && !lnk.link_ok_in) begin
      state_nxt = ALIGN;
      align_nxt = '0;
      per_nxt   = '0;
      burst_nxt = '0;
      cc_nxt    = cc_cnt;
    end
  end
endmodule
